// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle adder/subtractor that processes CHUNK bits per
// clock, least-significant chunk first, with the carry registered between
// chunks. The critical path is a single CHUNK-bit ripple, independent of WIDTH.
//
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-high reset, aborts any operation
//   start  - request an operation; accepted only in IDLE or DONE
//   sub    - 0: a + b + cin, 1: a - b (cin ignored)
//   a, b   - WIDTH-bit operands, captured on the accepted start edge
//   cin    - carry-in for add mode, captured on the accepted start edge
//   busy   - high while chunks are being processed
//   done   - one-cycle pulse when sum/cout/ovf are valid
//   sum    - WIDTH-bit result (modulo 2^WIDTH)
//   cout   - carry out of the MSB (sub mode: 1 = no borrow)
//   ovf    - two's-complement overflow
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [KW-1:0]    k_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic [CHUNK:0]   chunk_d;
  logic             msb_cin_d;
  logic             last_d;
  logic             accept_d;

  // Operand registers are shifted right each RUN cycle, so the current chunk
  // always sits in the low CHUNK bits and no variable-index mux is needed on
  // the operand side.
  always_comb begin
    chunk_d   = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
              + {{CHUNK{1'b0}}, carry_q};
    // Sum bit = a ^ b ^ carry_in, so the carry into the chunk's top bit is
    // recovered from the sum bit and the two operand bits.
    msb_cin_d = chunk_d[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];
    last_d    = (k_q == KW'(N - 1));
    accept_d  = start && ((state_q == IDLE) || (state_q == DONE));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          sum_q[k_q*CHUNK +: CHUNK] <= chunk_d[CHUNK-1:0];
          carry_q <= chunk_d[CHUNK];
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          k_q     <= k_q + KW'(1);
          if (last_d) begin
            cout_q  <= chunk_d[CHUNK];
            ovf_q   <= msb_cin_d ^ chunk_d[CHUNK];
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          done_q <= 1'b0;
          if (accept_d) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            k_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench for seq_chunk_adder: a 16/4 instance for the main
// scenarios plus 8/8 and 8/1 instances sharing one stimulus stream.
module tb_seq_chunk_adder;

  localparam int N16 = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, sub, cin;
  logic [15:0] a, b;
  logic        busy, done, cout, ovf;
  logic [15:0] sum;

  logic        start8, sub8, cin8;
  logic [7:0]  a8, b8;
  logic        busy8a, done8a, cout8a, ovf8a;
  logic [7:0]  sum8a;
  logic        busy8b, done8b, cout8b, ovf8b;
  logic [7:0]  sum8b;

  int   checks   = 0;
  int   failures = 0;
  logic prev_cout, prev_ovf;

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u16 (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) u8a (
    .clk(clk), .reset(reset), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8a), .done(done8a), .sum(sum8a), .cout(cout8a), .ovf(ovf8a)
  );

  seq_chunk_adder #(.WIDTH(8), .CHUNK(1)) u8b (
    .clk(clk), .reset(reset), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8b), .done(done8b), .sum(sum8b), .cout(cout8b), .ovf(ovf8b)
  );

  // Reference: integer arithmetic on unsigned and signed interpretations.
  // Returns {cout, ovf, sum[15:0]} for a w-bit operation.
  function automatic logic [17:0] model(input int w, input logic [15:0] x, input logic [15:0] y,
                                        input logic s, input logic c);
    longint m, ux, uy, sx, sy, r, sr;
    logic   co, ov;
    m  = longint'(1) << w;
    ux = longint'(x) & (m - 1);
    uy = longint'(y) & (m - 1);
    sx = (ux >= m / 2) ? ux - m : ux;
    sy = (uy >= m / 2) ? uy - m : uy;
    if (s) begin
      r  = ux - uy;
      co = (ux >= uy);
      sr = sx - sy;
    end else begin
      r  = ux + uy + longint'(c);
      co = (r >= m);
      sr = sx + sy + longint'(c);
    end
    ov = (sr >= m / 2) || (sr < -(m / 2));
    r  = r & (m - 1);
    return {co, ov, r[15:0]};
  endfunction

  // Issues one 16-bit op and checks busy timing, flag hold, and the result.
  // With chain=1 the caller is at the DONE-cycle negedge of the previous op.
  // Returns at the negedge where done should be high.
  task automatic run_op(input logic [15:0] xa, input logic [15:0] xb,
                        input logic xs, input logic xc, input bit chain);
    logic [17:0] e;
    e = model(16, xa, xb, xs, xc);
    if (!chain) @(negedge clk);
    a = xa; b = xb; sub = xs; cin = xc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    for (int i = 0; i < N16; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL run_busy cyc%0d: busy=%b done=%b expected busy=1 done=0", i, busy, done);
      end
      checks++;
      if ({cout, ovf} !== {prev_cout, prev_ovf}) begin
        failures++;
        $display("FAIL flags_hold cyc%0d: cout/ovf=%b%b expected %b%b", i, cout, ovf, prev_cout, prev_ovf);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse: done=%b busy=%b expected done=1 busy=0", done, busy);
    end
    checks++;
    if (sum !== e[15:0]) begin
      failures++;
      $display("FAIL sum %h%s%h: got %h expected %h", xa, xs ? "-" : "+", xb, sum, e[15:0]);
    end
    checks++;
    if (cout !== e[17]) begin
      failures++;
      $display("FAIL cout %h%s%h: got %b expected %b", xa, xs ? "-" : "+", xb, cout, e[17]);
    end
    checks++;
    if (ovf !== e[16]) begin
      failures++;
      $display("FAIL ovf %h%s%h: got %b expected %b", xa, xs ? "-" : "+", xb, ovf, e[16]);
    end
    prev_cout = e[17];
    prev_ovf  = e[16];
  endtask

  task automatic check_idle();
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_done: done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({busy, done, sum, cout, ovf} !== 20'h0) begin
      failures++;
      $display("FAIL reset16: busy=%b done=%b sum=%h cout=%b ovf=%b expected all 0", busy, done, sum, cout, ovf);
    end
    checks++;
    if ({busy8a, done8a, sum8a, cout8a, ovf8a, busy8b, done8b, sum8b, cout8b, ovf8b} !== 24'h0) begin
      failures++;
      $display("FAIL reset8: a=%b%b%h%b%b b=%b%b%h%b%b expected all 0", busy8a, done8a, sum8a, cout8a, ovf8a,
               busy8b, done8b, sum8b, cout8b, ovf8b);
    end
    @(negedge clk);
    reset = 1'b0;
    prev_cout = 1'b0;
    prev_ovf  = 1'b0;
  endtask

  task automatic test_directed();
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0); check_idle();
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0); check_idle();
    run_op(16'h7FFF, 16'h0000, 1'b0, 1'b1, 1'b0); check_idle();
    run_op(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0); check_idle();
    run_op(16'h0003, 16'h0005, 1'b1, 1'b1, 1'b0); check_idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      check_idle();
    end
  endtask

  task automatic test_start_ignored();
    logic [17:0] e;
    int          ndone;
    e = model(16, 16'hA5C3, 16'h1F0E, 1'b0, 1'b1);
    ndone = 0;
    @(negedge clk);
    a = 16'hA5C3; b = 16'h1F0E; sub = 1'b0; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int j = 1; j <= N16 + 4; j++) begin
      @(negedge clk);
      if (j == 2) begin
        a = 16'h0F0F; b = 16'h7777; sub = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        ndone++;
        checks++;
        if (j != N16 + 1) begin
          failures++;
          $display("FAIL ignored_done_time: done at cycle %0d expected %0d", j, N16 + 1);
        end
        checks++;
        if ({cout, ovf, sum} !== e) begin
          failures++;
          $display("FAIL ignored_result: got %b%b%h expected %b%b%h", cout, ovf, sum, e[17], e[16], e[15:0]);
        end
      end
    end
    checks++;
    if (ndone != 1) begin
      failures++;
      $display("FAIL ignored_done_count: got %0d expected 1", ndone);
    end
    prev_cout = e[17];
    prev_ovf  = e[16];
  endtask

  task automatic test_back_to_back();
    run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b1);
    run_op(16'h0000, 16'h0001, 1'b1, 1'b0, 1'b1);
    run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    check_idle();
  endtask

  task automatic test_reset_mid();
    int ndone;
    ndone = 0;
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, sum, cout, ovf} !== 20'h0) begin
      failures++;
      $display("FAIL async_reset: busy=%b done=%b sum=%h cout=%b ovf=%b expected all 0", busy, done, sum, cout, ovf);
    end
    @(negedge clk);
    reset = 1'b0;
    prev_cout = 1'b0;
    prev_ovf  = 1'b0;
    for (int j = 0; j < N16 + 3; j++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_abort: done pulses=%0d busy=%b expected 0 0", ndone, busy);
    end
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    check_idle();
  endtask

  task automatic run8(input logic [7:0] xa, input logic [7:0] xb, input logic xs, input logic xc);
    logic [17:0] e;
    int          seen_a, seen_b;
    e = model(8, {8'h00, xa}, {8'h00, xb}, xs, xc);
    seen_a = 0;
    seen_b = 0;
    @(negedge clk);
    a8 = xa; b8 = xb; sub8 = xs; cin8 = xc; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom); cin8 = 1'($urandom);
    for (int j = 1; j <= 11; j++) begin
      @(negedge clk);
      if (done8a === 1'b1) begin
        seen_a++;
        checks++;
        if (j != 2 || {cout8a, ovf8a, sum8a} !== {e[17:16], e[7:0]}) begin
          failures++;
          $display("FAIL w8c8 %h%s%h: cycle %0d result %b%b%h expected cycle 2 result %b%b%h",
                   xa, xs ? "-" : "+", xb, j, cout8a, ovf8a, sum8a, e[17], e[16], e[7:0]);
        end
      end
      if (done8b === 1'b1) begin
        seen_b++;
        checks++;
        if (j != 9 || {cout8b, ovf8b, sum8b} !== {e[17:16], e[7:0]}) begin
          failures++;
          $display("FAIL w8c1 %h%s%h: cycle %0d result %b%b%h expected cycle 9 result %b%b%h",
                   xa, xs ? "-" : "+", xb, j, cout8b, ovf8b, sum8b, e[17], e[16], e[7:0]);
        end
      end
    end
    checks++;
    if (seen_a != 1 || seen_b != 1) begin
      failures++;
      $display("FAIL w8_done_count: got %0d/%0d expected 1/1", seen_a, seen_b);
    end
  endtask

  task automatic test_width8();
    run8(8'h80, 8'h80, 1'b0, 1'b0);
    run8(8'h7F, 8'h00, 1'b0, 1'b1);
    run8(8'h03, 8'h05, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++)
      run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    prev_cout = 1'b0;
    prev_ovf  = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_width8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_chunk_adder.md
# seq_chunk_adder

Parametrised multi-cycle adder/subtractor that replaces fixed-width combinational ripple adders where operand width or timing closure makes a single-cycle carry chain unacceptable. Operands are added CHUNK bits per clock, least-significant chunk first, with the carry registered between chunks. The block uses a start/done handshake. It also provides subtract mode, carry-out and signed-overflow flags. It sits between operand registers and any consumer that can wait WIDTH/CHUNK + 1 cycles for a result.

## Interface
- WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle; 1 ≤ CHUNK ≤ WIDTH.

- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; returns the block to IDLE immediately.
- start  input  1  request to begin an operation; sampled only when busy = 0.
- sub  input  1  0 = add (a + b + cin); 1 = subtract (a − b; cin ignored).
- a  input  WIDTH  first operand; captured on the accepted start edge.
- b  input  WIDTH  second operand; captured on the accepted start edge.
- cin  input  1  carry-in for add mode; captured on the accepted start edge.
- busy  output  1  high while chunks are being processed (RUN state).
- done  output  1  one-cycle pulse marking that sum/cout/ovf are valid.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB; in sub mode, 1 means no borrow.
- ovf  output  1  two's-complement overflow, equal to carry into MSB XOR cout.

## Operation
- States:
  - IDLE: after reset.
  - RUN: processes chunks.
  - DONE: lasts one cycle and drives done = 1.
- Accepted start (state IDLE or DONE, start = 1):
  - Latch a.
  - Latch b_eff = sub ? ~b : b.
  - Set carry = sub ? 1 : cin.
  - Set chunk index k = 0, then enter RUN.
- RUN, one cycle per chunk:
  - Compute {c, s} = a[k] + b_eff[k] + carry over CHUNK bits.
  - Write s into sum[k*CHUNK +: CHUNK] and register c as the new carry.
  - On the final chunk (k = N−1, N = WIDTH/CHUNK):
    - Record the carry into the MSB, i.e. the carry into bit WIDTH−1 inside the last chunk.
    - Set cout = c and ovf = carry_into_MSB ^ c.
    - Enter DONE.
- DONE lasts one cycle: done = 1, busy = 0, then go to IDLE. If start = 1 during DONE, it is accepted and the next state is RUN.
- start while in RUN is ignored; there is no queuing.
- Outputs sum/cout/ovf hold their values from DONE until the next accepted start. From that start onward, sum is partially overwritten chunk by chunk, and cout/ovf keep their old values until the new final chunk.
- Reset values: state = IDLE, busy = 0, done = 0, sum = 0, cout = 0, ovf = 0, k = 0, carry = 0.
- Reset asserted mid-operation aborts the operation with no done pulse. All outputs go to their reset values asynchronously.

## Timing
- Accepted start at edge T: busy = 1 during cycles T+1 … T+N.
- done = 1 for exactly one cycle, after edge T+N, i.e. latency N+1 edges from start to done.
- With CHUNK = WIDTH, N = 1: busy is high for one cycle and done follows on the next cycle.
- Maximum throughput is one operation per N+1 cycles, achieved by asserting start during DONE.
- Operand inputs may change freely after the accepted start edge. Only the captured copies are used.
- The critical path is one CHUNK-bit ripple plus the carry register; it is independent of WIDTH.

## Test plan
- WIDTH = 16, CHUNK = 4, add 0x1234 + 0x4321 with cin = 0 → sum = 0x5555, cout = 0, ovf = 0. done pulses one cycle, 5 edges after start. busy is high for 4 cycles.
- Add 0xFFFF + 0x0001 with cin = 0 → sum = 0x0000, cout = 1, ovf = 0. Then add 0x7FFF + 0x0000 with cin = 1 → sum = 0x8000, cout = 0, ovf = 1.
- sub = 1, 0x8000 − 0x0001 → sum = 0x7FFF, cout = 1, ovf = 1. Then 0x0003 − 0x0005 → sum = 0xFFFE, cout = 0, ovf = 0.
- Pulse start again 2 cycles into RUN with different operands → ignored; the original result and a single done pulse are produced. Start asserted during DONE → the new operation begins and its done appears N+1 edges later.
- Assert reset 2 cycles into RUN, asynchronously between edges → busy, sum, cout and ovf are 0 before the next edge, no done pulse appears, and a later start operates normally.
- WIDTH = 8, CHUNK = 8: 0x80 + 0x80 → sum = 0x00, cout = 1, ovf = 1, with done at the second edge after start. WIDTH = 8, CHUNK = 1: same operands give the same result, with done at edge 9.
